// File: rtl/rv_fetch_unit.sv
// RV32I instruction-fetch stage: owns the fetch PC, issues word reads to instruction
// memory and presents returned instructions in order, with their PC, through a 2-entry queue.
module rv_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   input  logic        if_ready
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // a valid that is not accepted keeps its payload stable until it is (or a redirect flushes it).
   logic [31:0] fetch_pc;
   logic [31:0] head_pc;
   logic [1:0]  inflight;
   logic [1:0]  drop;
   logic [1:0]  count;
   logic        started;
   logic [31:0] fifo_mem [2];
   logic        rd_ptr;
   logic        wr_ptr;

   logic        req_fire;
   logic        if_fire;
   logic        keep;
   logic        push;
   logic [2:0]  credit_used;
   logic [1:0]  inflight_next;
   logic [1:0]  count_next;
   logic [31:0] target_pc;
   logic        unused_pc_bits;

   assign target_pc      = {redirect_pc[31:2], 2'b00};
   assign unused_pc_bits = ^redirect_pc[1:0];

   assign if_valid = (count != 2'd0) && !redirect_valid;
   assign if_fire  = if_valid && if_ready;
   assign if_pc    = head_pc;
   assign if_instr = fifo_mem[rd_ptr];

   // Slots are reserved for everything in flight plus everything buffered, so a
   // returning response always has room; an instruction leaving this cycle frees one.
   assign credit_used    = {1'b0, inflight} + {1'b0, count} - {2'b00, if_fire};
   assign imem_req_valid = started && !redirect_valid && (credit_used < 3'd2);
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign keep = imem_rsp_valid && (drop == 2'd0);
   assign push = keep && !redirect_valid;

   always_comb begin
      inflight_next = inflight;
      if (req_fire && !imem_rsp_valid) begin
         inflight_next = inflight + 2'd1;
      end else if (!req_fire && imem_rsp_valid) begin
         inflight_next = inflight - 2'd1;
      end
   end

   always_comb begin
      count_next = count;
      if (push && !if_fire) begin
         count_next = count + 2'd1;
      end else if (!push && if_fire) begin
         count_next = count - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         head_pc     <= RESET_PC;
         inflight    <= 2'd0;
         drop        <= 2'd0;
         count       <= 2'd0;
         started     <= 1'b0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         fifo_mem[0] <= 32'd0;
         fifo_mem[1] <= 32'd0;
      end else begin
         started  <= 1'b1;
         inflight <= inflight_next;
         if (redirect_valid) begin
            // Every request still outstanding belongs to the wrong path.
            fetch_pc <= target_pc;
            head_pc  <= target_pc;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            drop     <= inflight_next;
         end else begin
            if (req_fire) begin
               fetch_pc <= fetch_pc + 32'd4;
            end
            if (imem_rsp_valid && (drop != 2'd0)) begin
               drop <= drop - 2'd1;
            end
            if (push) begin
               fifo_mem[wr_ptr] <= imem_rsp_data;
               wr_ptr           <= ~wr_ptr;
            end
            if (if_fire) begin
               rd_ptr  <= ~rd_ptr;
               head_pc <= head_pc + 32'd4;
            end
            count <= count_next;
         end
      end
   end

   a_rsp_needs_request: assert property (@(posedge clk) disable iff (!rst_n)
      imem_rsp_valid |-> (inflight != 2'd0));

   a_drop_within_inflight: assert property (@(posedge clk) disable iff (!rst_n)
      drop <= inflight);

   a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && (count == 2'd2) && !if_fire));

endmodule
